// File: rtl/prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: request FSM states and
// the fill byte-count rule.
package prefetch_queue_pkg;

  typedef enum logic [1:0] {PFQ_IDLE, PFQ_REQ, PFQ_WAIT} pfq_state_e;

  // A wide request answered with both bus lanes yields two bytes, otherwise one.
  function automatic logic [1:0] byte_count(input logic wide, input logic bs16);
    return (wide && bs16) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/pfq_rotate.sv
// Barrel rotator: presents the ring as a window starting at rd_ptr,
// so window byte k is ring entry (rd_ptr + k) mod DEPTH.
module pfq_rotate #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][7:0] ring,
  input  logic [PW-1:0]         rd_ptr,
  output logic [DEPTH-1:0][7:0] window
);

  for (genvar k = 0; k < DEPTH; k++) begin : g_lane
    assign window[k] = ring[rd_ptr + PW'(k)];
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues code fetches at pfp, buffers returned
// bytes in a ring and exposes a head-aligned window to the decoder.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter  int DEPTH       = 8,
  parameter  int BUS_BYTES   = 2,
  parameter  int MAX_CONSUME = 6,
  localparam int PW          = $clog2(DEPTH),
  localparam int UW          = $clog2(DEPTH + 1),
  localparam int CW          = $clog2(MAX_CONSUME + 1)
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   ce,
  input  logic                   flush,
  input  logic [15:0]            flush_addr,
  input  logic [CW-1:0]          consume,
  output logic                   fetch_req,
  output logic [15:0]            fetch_addr,
  output logic                   fetch_wide,
  input  logic                   fetch_ack,
  input  logic                   fill_valid,
  input  logic [8*BUS_BYTES-1:0] fill_data,
  input  logic                   fill_bs16,
  output logic [UW-1:0]          q_used,
  output logic [8*DEPTH-1:0]     q_window,
  output logic [15:0]            ip,
  output logic                   fault
);

  localparam int AW = UW + 1;

  pfq_state_e            state;
  logic                  pending, discard;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [15:0]           pfp;
  logic [DEPTH-1:0][7:0] ring;

  logic                  fill_take, pend_nx, over, req_ok;
  logic [1:0]            wr_cnt;
  logic [AW-1:0]         avail, cons_eff, used_nx;
  int                    free;

  assign fetch_addr = pfp;
  // An odd pfp forces a byte fetch so the following requests are word aligned.
  assign fetch_wide = (BUS_BYTES == 2) && !pfp[0];

  always_comb begin
    fill_take = pending && fill_valid;
    wr_cnt    = (fill_take && !discard) ? byte_count(fetch_wide, fill_bs16) : 2'd0;
    avail     = AW'(q_used) + AW'(wr_cnt);
    // Bytes arriving this cycle count as available to the same-cycle consume.
    over      = AW'(consume) > avail;
    cons_eff  = over ? avail : AW'(consume);
    used_nx   = avail - cons_eff;
    pend_nx   = pending && !fill_valid;
    free      = DEPTH - int'(used_nx) - (pend_nx ? BUS_BYTES : 0);
    req_ok    = free >= BUS_BYTES;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= PFQ_IDLE;
      fetch_req <= 1'b0;
      pending   <= 1'b0;
      discard   <= 1'b0;
      fault     <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_used    <= '0;
      pfp       <= '0;
      ip        <= '0;
      ring      <= '0;
    end else if (ce) begin
      if (flush) begin
        rd_ptr    <= wr_ptr;
        q_used    <= '0;
        pfp       <= flush_addr;
        ip        <= flush_addr;
        fetch_req <= 1'b0;
        // A fetch still owned by the BCU must have its data dropped on return.
        if ((pending && !fill_valid) || (state == PFQ_REQ && fetch_ack)) begin
          state   <= PFQ_WAIT;
          pending <= 1'b1;
          discard <= 1'b1;
        end else begin
          state   <= PFQ_IDLE;
          pending <= 1'b0;
          discard <= 1'b0;
        end
      end else begin
        if (over) fault <= 1'b1;
        rd_ptr <= rd_ptr + PW'(cons_eff);
        ip     <= ip + 16'(cons_eff);
        q_used <= UW'(used_nx);
        wr_ptr <= wr_ptr + PW'(wr_cnt);
        pfp    <= pfp + 16'(wr_cnt);
        if (wr_cnt != 2'd0) ring[wr_ptr] <= fill_data[7:0];
        if (wr_cnt == 2'd2) ring[wr_ptr + PW'(1)] <= fill_data[8*BUS_BYTES-1 -: 8];

        case (state)
          PFQ_IDLE: begin
            if (req_ok && !discard) begin
              state     <= PFQ_REQ;
              fetch_req <= 1'b1;
            end
          end
          PFQ_REQ: begin
            if (fetch_ack) begin
              state     <= PFQ_WAIT;
              fetch_req <= 1'b0;
              pending   <= 1'b1;
            end
          end
          PFQ_WAIT: begin
            if (fill_valid) begin
              pending <= 1'b0;
              discard <= 1'b0;
              if (req_ok) begin
                state     <= PFQ_REQ;
                fetch_req <= 1'b1;
              end else begin
                state     <= PFQ_IDLE;
              end
            end
          end
          default: state <= PFQ_IDLE;
        endcase
      end
    end
  end

  pfq_rotate #(.DEPTH(DEPTH)) u_rot (
    .ring   (ring),
    .rd_ptr (rd_ptr),
    .window (q_window)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: acts as the BCU, tracks the expected byte stream
// in a queue model and checks window, counts, addresses and request gating.
module tb_prefetch_queue;
  localparam int DEPTH = 8, BUS = 2, MAXC = 6;

  logic        clk = 0, n_reset = 0, ce = 1, flush = 0;
  logic [15:0] flush_addr = 0;
  logic [2:0]  consume = 0;
  logic        fetch_req, fetch_wide, fault;
  logic        fetch_ack = 0, fill_valid = 0, fill_bs16 = 0;
  logic [15:0] fetch_addr, ip;
  logic [15:0] fill_data = 0;
  logic [3:0]  q_used;
  logic [63:0] q_window;

  int total = 0, bad = 0;

  byte unsigned mq[$];
  logic [15:0]  m_ip, m_pfp;
  logic         m_fault, m_out, m_disc;

  prefetch_queue #(.DEPTH(DEPTH), .BUS_BYTES(BUS), .MAX_CONSUME(MAXC)) dut (
    .clk(clk), .n_reset(n_reset), .ce(ce), .flush(flush), .flush_addr(flush_addr),
    .consume(consume), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_wide(fetch_wide), .fetch_ack(fetch_ack), .fill_valid(fill_valid),
    .fill_data(fill_data), .fill_bs16(fill_bs16), .q_used(q_used),
    .q_window(q_window), .ip(ip), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ip = 0; m_pfp = 0; m_fault = 0; m_out = 0; m_disc = 0;
  endtask

  // Expected effect of one clock edge, from the queue's byte-stream rules.
  task automatic model_step();
    int n, c;
    if (!n_reset || !ce) return;
    if (flush) begin
      mq.delete();
      m_ip = flush_addr; m_pfp = flush_addr;
      if (fetch_ack || (m_out && !fill_valid)) begin m_out = 1; m_disc = 1; end
      else begin m_out = 0; m_disc = 0; end
      return;
    end
    if (fill_valid && m_out) begin
      if (!m_disc) begin
        n = (!m_pfp[0] && fill_bs16) ? 2 : 1;
        for (int i = 0; i < n; i++) mq.push_back(fill_data[8*i +: 8]);
        m_pfp += 16'(n);
      end
      m_out = 0; m_disc = 0;
    end
    if (fetch_ack) m_out = 1;
    c = int'(consume);
    if (c > mq.size()) begin m_fault = 1; c = mq.size(); end
    for (int i = 0; i < c; i++) void'(mq.pop_front());
    m_ip += 16'(c);
  endtask

  task automatic auto_check();
    logic [63:0] ew, mk;
    ew = '0; mk = '0;
    foreach (mq[k]) begin ew[8*k +: 8] = mq[k]; mk[8*k +: 8] = 8'hFF; end
    chk("used", 64'(q_used), 64'(mq.size()));
    chk("ip", 64'(ip), 64'(m_ip));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("window", q_window & mk, ew);
    if (fetch_req) begin
      chk("req_addr", 64'(fetch_addr), 64'(m_pfp));
      chk("req_wide", 64'(fetch_wide), 64'(!m_pfp[0]));
      chk("req_room", 64'(!m_out && mq.size() <= DEPTH - BUS), 64'(1));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    auto_check();
  endtask

  task automatic wait_req();
    int i = 0;
    while (!fetch_req && i < 20) begin cyc(); i++; end
    chk("req_timeout", 64'(fetch_req), 64'(1));
  endtask

  task automatic do_fetch(input logic [15:0] d, input logic bs);
    wait_req();
    fetch_ack = 1; cyc(); fetch_ack = 0;
    fill_valid = 1; fill_data = d; fill_bs16 = bs; cyc(); fill_valid = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(fetch_req), 0);
    chk("rst_used", 64'(q_used), 0);
    chk("rst_ip", 64'(ip), 0);
    chk("rst_fault", 64'(fault), 0);
    chk("rst_window", q_window, 0);
    chk("rst_addr", 64'(fetch_addr), 0);
    n_reset = 1;

    // Basic fill after redirect
    flush = 1; flush_addr = 16'h0100; cyc(); flush = 0;
    do_fetch(16'h1211, 1);
    do_fetch(16'h3413, 1);
    chk("t1_used", 64'(q_used), 4);
    chk("t1_win", 64'(q_window[31:0]), 64'h34131211);
    chk("t1_ip", 64'(ip), 16'h0100);
    chk("t1_pfp", 64'(fetch_addr), 16'h0104);

    // Clock enable low freezes everything
    ce = 0; consume = 2; cyc(); ce = 1; consume = 0;
    chk("ce_hold", 64'(q_used), 4);

    // Odd redirect: byte fetch realigns, then wide fetches
    flush = 1; flush_addr = 16'h0201; cyc(); flush = 0;
    chk("t2_withdraw", 64'(fetch_req), 0);
    cyc();
    chk("t2_req", 64'(fetch_req), 1);
    chk("t2_addr", 64'(fetch_addr), 16'h0201);
    chk("t2_narrow", 64'(fetch_wide), 0);
    do_fetch(16'h00AB, 1);
    chk("t2_addr2", 64'(fetch_addr), 16'h0202);
    chk("t2_wide2", 64'(fetch_wide), 1);
    do_fetch(16'h2221, 1);
    chk("t2_addr3", 64'(fetch_addr), 16'h0204);
    chk("t2_wide3", 64'(fetch_wide), 1);

    // Fill towards full with no consume
    do_fetch(16'h4443, 1);
    do_fetch(16'h0055, 0);
    do_fetch(16'h7766, 1);
    chk("t3_used7", 64'(q_used), 7);
    chk("t3_noreq7", 64'(fetch_req), 0);
    cyc();
    chk("t3_noreq7b", 64'(fetch_req), 0);
    consume = 1; cyc(); consume = 0;
    chk("t3_req6", 64'(fetch_req), 1);
    do_fetch(16'h9988, 1);
    chk("t3_used8", 64'(q_used), 8);
    chk("t3_noreq8", 64'(fetch_req), 0);
    cyc();
    chk("t3_noreq8b", 64'(fetch_req), 0);
    consume = 2; cyc(); consume = 0;
    chk("t3_reassert", 64'(fetch_req), 1);

    // Same-cycle fill and consume, then over-consume
    fetch_ack = 1; consume = 3; cyc(); fetch_ack = 0; consume = 0;
    chk("t4_used3", 64'(q_used), 3);
    fill_valid = 1; fill_data = 16'hBBAA; fill_bs16 = 1; consume = 4; cyc();
    fill_valid = 0; consume = 0;
    chk("t4_used1", 64'(q_used), 1);
    chk("t4_nofault", 64'(fault), 0);
    consume = 3; cyc(); consume = 0;
    chk("t4_used0", 64'(q_used), 0);
    chk("t4_fault", 64'(fault), 1);
    cyc();
    chk("t4_sticky", 64'(fault), 1);

    // Flush while a fetch is in flight
    wait_req();
    fetch_ack = 1; cyc(); fetch_ack = 0;
    flush = 1; flush_addr = 16'h3000; cyc(); flush = 0;
    cyc();
    chk("t5_noreq", 64'(fetch_req), 0);
    fill_valid = 1; fill_data = 16'hDEAD; fill_bs16 = 1; cyc(); fill_valid = 0;
    chk("t5_dropped", 64'(q_used), 0);
    chk("t5_req", 64'(fetch_req), 1);
    chk("t5_addr", 64'(fetch_addr), 16'h3000);

    // Flush in the same cycle the request is accepted
    fetch_ack = 1; flush = 1; flush_addr = 16'h4001; cyc(); fetch_ack = 0; flush = 0;
    chk("t5b_noreq", 64'(fetch_req), 0);
    fill_valid = 1; fill_data = 16'h1111; cyc(); fill_valid = 0;
    chk("t5b_dropped", 64'(q_used), 0);
    chk("t5b_addr", 64'(fetch_addr), 16'h4001);

    // Address wrap at the top of the segment
    flush = 1; flush_addr = 16'hFFFE; cyc(); flush = 0;
    wait_req();
    chk("t6_addr", 64'(fetch_addr), 16'hFFFE);
    chk("t6_wide", 64'(fetch_wide), 1);
    do_fetch(16'h0201, 1);
    chk("t6_pfpwrap", 64'(fetch_addr), 16'h0000);
    consume = 2; cyc(); consume = 0;
    chk("t6_ipwrap", 64'(ip), 16'h0000);

    // Reset while a fetch is pending; the late fill must be ignored
    wait_req();
    fetch_ack = 1; cyc(); fetch_ack = 0;
    n_reset = 0; #1;
    model_reset();
    chk("t7_used", 64'(q_used), 0);
    chk("t7_req", 64'(fetch_req), 0);
    chk("t7_ip", 64'(ip), 0);
    n_reset = 1;
    fill_valid = 1; fill_data = 16'h5555; fill_bs16 = 1; cyc(); fill_valid = 0;
    chk("t7_late", 64'(q_used), 0);

    // Randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      ce         = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      flush_addr = 16'($urandom);
      consume    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, MAXC)) : 3'd0;
      fetch_ack  = fetch_req && ($urandom_range(0, 1) == 1);
      fill_valid = m_out && ($urandom_range(0, 2) == 0);
      fill_data  = 16'($urandom);
      fill_bs16  = 1'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
